// File: rtl/cpu_bank_reg_mp.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bank_reg_mp
// Description : Parametrised multi-port CPU register bank. N write ports
//               (highest port wins on a shared target), M combinational read
//               ports, a per-register pending scoreboard for the issue stage,
//               and a sequenced bulk-clear engine used on context switch.
//               Optional read-during-write forwarding: CPU_BANK_REG_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bank_reg_mp #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  localparam int ADDR_W  = $clog2(REG_NUM)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_pending,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  output logic                         wr_ready,
  input  logic                         pend_set_en,
  input  logic [ADDR_W-1:0]            pend_set_addr,
  output logic                         wr_conflict,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   regs_q [REG_NUM];
  logic [DATA_W-1:0]   regs_d [REG_NUM];
  logic [REG_NUM-1:0]  pend_q, pend_d;
  logic                conflict_q, conflict_d;

  // Per-register write resolution for the current cycle
  logic                w_accept;
  logic [REG_NUM-1:0]  w_hit;
  logic [DATA_W-1:0]   w_hdata [REG_NUM];
  logic [REG_NUM-1:0]  w_set;

  assign w_accept    = (state_q != ST_CLEAR);
  assign wr_conflict = conflict_q;

  // Resolve which register each write port targets; later ports overwrite earlier ones
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_hit[r]   = 1'b0;
      w_hdata[r] = '0;
      w_set[r]   = 1'b0;
      if (r != 0) begin
        for (int k = 0; k < WR_PORTS; k++) begin
          if (w_accept && wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            w_hit[r]   = 1'b1;
            w_hdata[r] = wr_data[k*DATA_W +: DATA_W];
          end
        end
        w_set[r] = w_accept && pend_set_en && (pend_set_addr == ADDR_W'(r));
      end
    end
  end

  // Detect two or more enabled ports hitting the same nonzero index this cycle
  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < WR_PORTS; j++) begin
      for (int k = j + 1; k < WR_PORTS; k++) begin
        if (w_accept && wr_en[j] && wr_en[k] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]) &&
            (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Clear-engine next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    wr_ready = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        wr_ready = 1'b0;
        idx_d    = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(REG_NUM - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next register and scoreboard contents: writes clear pending, a same-cycle set wins,
  // the clear engine zeroes one entry per cycle, and entry 0 is pinned to zero
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int r = 0; r < REG_NUM; r++) begin
      if (w_hit[r]) begin
        regs_d[r] = w_hdata[r];
        pend_d[r] = 1'b0;
      end
      if (w_set[r]) begin
        pend_d[r] = 1'b1;
      end
    end
    if (state_q == ST_CLEAR) begin
      regs_d[idx_q] = '0;
      pend_d[idx_q] = 1'b0;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  // State, index, storage and conflict flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      conflict_q <= 1'b0;
      for (int r = 0; r < REG_NUM; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
      for (int r = 0; r < REG_NUM; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Combinational read ports
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_pend;

    assign w_a     = rd_addr[p*ADDR_W +: ADDR_W];
    assign w_valid = (w_a != '0) && (int'(w_a) < REG_NUM);

    // Select stored (or forwarded) value for this port; index 0 and out-of-range read zero
    always_comb begin
      w_data = '0;
      w_pend = 1'b0;
      if (w_valid) begin
        w_data = regs_q[w_a];
        w_pend = pend_q[w_a];
`ifdef CPU_BANK_REG_BYPASS_EN
        if (w_hit[w_a]) begin
          w_data = w_hdata[w_a];
          w_pend = w_set[w_a];
        end
`endif
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = w_data;
    assign rd_pending[p]               = w_pend;
  end

endmodule
`default_nettype wire
